// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for the 8-bit up/down counter: button rising-edge detection,
// IDLE/RUN/PAUSE/LOAD state machine, count-step prescaler and one-shot terminal detect.
module counter_seq_ctrl #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 100000000,
    parameter int TICK_W   = 27
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start_btn,
    input  logic             load_btn,
    input  logic             mode_btn,
    input  logic             clear_btn,
    input  logic             run_sw,
    input  logic             one_shot,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] q,
    output logic             cnt_clr,
    output logic             cnt_load,
    output logic [WIDTH-1:0] load_val,
    output logic             cnt_step,
    output logic             cnt_up,
    output logic [1:0]       state,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_LOAD  = 2'b11
    } state_t;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    state_t             r_state, w_state_nxt;
    logic [TICK_W-1:0]  r_presc, w_presc_nxt;
    logic               r_cnt_clr, w_cnt_clr_nxt;
    logic               r_cnt_load, w_cnt_load_nxt;
    logic               r_cnt_step, w_cnt_step_nxt;
    logic               r_done, w_done_nxt;
    logic               r_cnt_up, w_cnt_up_nxt;
    logic [WIDTH-1:0]   r_load_val, w_load_val_nxt;
    logic               r_start_q, r_load_q, r_mode_q, r_clear_q;

    logic w_start_rise, w_load_rise, w_mode_rise, w_clear_rise;
    logic w_tick, w_terminal;

    assign w_start_rise = start_btn & ~r_start_q;
    assign w_load_rise  = load_btn  & ~r_load_q;
    assign w_mode_rise  = mode_btn  & ~r_mode_q;
    assign w_clear_rise = clear_btn & ~r_clear_q;

    assign w_tick     = (r_presc == TICK_LAST);
    assign w_terminal = r_cnt_up ? (&q) : ~(|q);

    // History registers reset to 1 so a button held through reset yields no edge.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_cnt_clr  <= 1'b0;
            r_cnt_load <= 1'b0;
            r_cnt_step <= 1'b0;
            r_done     <= 1'b0;
            r_cnt_up   <= 1'b1;
            r_load_val <= '0;
            r_start_q  <= 1'b1;
            r_load_q   <= 1'b1;
            r_mode_q   <= 1'b1;
            r_clear_q  <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_presc    <= w_presc_nxt;
            r_cnt_clr  <= w_cnt_clr_nxt;
            r_cnt_load <= w_cnt_load_nxt;
            r_cnt_step <= w_cnt_step_nxt;
            r_done     <= w_done_nxt;
            r_cnt_up   <= w_cnt_up_nxt;
            r_load_val <= w_load_val_nxt;
            r_start_q  <= start_btn;
            r_load_q   <= load_btn;
            r_mode_q   <= mode_btn;
            r_clear_q  <= clear_btn;
        end
    end

    // NOTE: every next-state signal gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_presc_nxt    = r_presc;
        w_cnt_clr_nxt  = 1'b0;
        w_cnt_load_nxt = 1'b0;
        w_cnt_step_nxt = 1'b0;
        w_done_nxt     = 1'b0;
        w_cnt_up_nxt   = r_cnt_up ^ w_mode_rise;
        w_load_val_nxt = r_load_val;

        if (w_clear_rise) begin
            w_cnt_clr_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
            w_presc_nxt   = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_load_rise) begin
                        w_state_nxt    = S_LOAD;
                        w_cnt_load_nxt = 1'b1;
                        w_load_val_nxt = data;
                    end else if (w_start_rise) begin
                        w_state_nxt = S_RUN;
                        w_presc_nxt = '0;
                    end
                end
                S_RUN: begin
                    // The prescaler keeps its phase through a pause; a command only drops the tick.
                    if (run_sw)
                        w_presc_nxt = w_tick ? '0 : r_presc + TICK_W'(1);
                    if (w_load_rise) begin
                        w_state_nxt    = S_LOAD;
                        w_cnt_load_nxt = 1'b1;
                        w_load_val_nxt = data;
                    end else if (w_start_rise) begin
                        w_state_nxt = S_PAUSE;
                    end else if (run_sw && w_tick) begin
                        if (one_shot && w_terminal) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_cnt_step_nxt = 1'b1;
                        end
                    end
                end
                S_PAUSE: begin
                    if (w_load_rise) begin
                        w_state_nxt    = S_LOAD;
                        w_cnt_load_nxt = 1'b1;
                        w_load_val_nxt = data;
                    end else if (w_start_rise) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_LOAD: begin
                    w_state_nxt = S_PAUSE;
                    w_presc_nxt = '0;
                end
            endcase
        end
    end

    assign cnt_clr  = r_cnt_clr;
    assign cnt_load = r_cnt_load;
    assign load_val = r_load_val;
    assign cnt_step = r_cnt_step;
    assign cnt_up   = r_cnt_up;
    assign state    = r_state;
    assign done     = r_done;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl: a behavioural model queues the expected outputs
// for each clock edge, and a negedge monitor compares them against the DUT.
module tb_counter_seq_ctrl;

    localparam int WIDTH    = 8;
    localparam int TICK_DIV = 4;
    localparam int TICK_W   = 3;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_LOAD  = 2'b11;

    logic             clk = 1'b0;
    logic             clr_n = 1'b0;
    logic             start_btn = 1'b0, load_btn = 1'b0, mode_btn = 1'b0, clear_btn = 1'b0;
    logic             run_sw = 1'b1, one_shot = 1'b0;
    logic [WIDTH-1:0] data = '0, q = '0;
    logic             cnt_clr, cnt_load, cnt_step, cnt_up, done;
    logic [WIDTH-1:0] load_val;
    logic [1:0]       state;

    counter_seq_ctrl #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .TICK_W(TICK_W)) dut (
        .clk(clk), .clr_n(clr_n),
        .start_btn(start_btn), .load_btn(load_btn), .mode_btn(mode_btn), .clear_btn(clear_btn),
        .run_sw(run_sw), .one_shot(one_shot), .data(data), .q(q),
        .cnt_clr(cnt_clr), .cnt_load(cnt_load), .load_val(load_val),
        .cnt_step(cnt_step), .cnt_up(cnt_up), .state(state), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    always @(posedge clk) cyc_n = cyc_n + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc_n, got, exp);
        end
    endtask

    // {state, cnt_up, cnt_clr, cnt_load, cnt_step, done, load_val}
    typedef struct {
        int          cyc;
        logic [14:0] outs;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: what the controller is doing, tracked in plain terms.
    logic [1:0]       m_mode;
    int               m_phase;      // clk cycles into the current count period
    bit               m_up;
    logic [WIDTH-1:0] m_lv;
    bit               m_prev_start, m_prev_load, m_prev_mode, m_prev_clear;

    task automatic model_reset();
        m_mode = ST_IDLE; m_phase = 0; m_up = 1'b1; m_lv = '0;
        m_prev_start = 1'b1; m_prev_load = 1'b1; m_prev_mode = 1'b1; m_prev_clear = 1'b1;
    endtask

    // Predict outputs after the coming clock edge from the inputs currently applied.
    task automatic model_step();
        exp_t e;
        bit pr_start, pr_load, pr_mode, pr_clear, ticked, terminal;
        bit clr_o, load_o, step_o, done_o;
        logic [1:0] nxt;
        pr_start = start_btn && !m_prev_start;
        pr_load  = load_btn  && !m_prev_load;
        pr_mode  = mode_btn  && !m_prev_mode;
        pr_clear = clear_btn && !m_prev_clear;
        terminal = m_up ? (q == 8'hFF) : (q == 8'h00);
        clr_o = 0; load_o = 0; step_o = 0; done_o = 0; ticked = 0;
        nxt = m_mode;
        if (m_mode == ST_RUN && run_sw) begin
            ticked  = (m_phase == TICK_DIV - 1);
            m_phase = (m_phase + 1) % TICK_DIV;
        end
        if (pr_clear) begin
            clr_o = 1; nxt = ST_IDLE; m_phase = 0;
        end else if (m_mode == ST_LOAD) begin
            nxt = ST_PAUSE; m_phase = 0;
        end else if (pr_load) begin
            load_o = 1; nxt = ST_LOAD; m_lv = data;
        end else if (pr_start) begin
            if (m_mode == ST_RUN) nxt = ST_PAUSE;
            else nxt = ST_RUN;
            if (m_mode == ST_IDLE) m_phase = 0;
        end else if (ticked) begin
            if (one_shot && terminal) begin
                done_o = 1; nxt = ST_IDLE;
            end else begin
                step_o = 1;
            end
        end
        if (pr_mode) m_up = !m_up;
        m_mode = nxt;
        m_prev_start = start_btn; m_prev_load = load_btn;
        m_prev_mode = mode_btn;   m_prev_clear = clear_btn;
        e.cyc  = cyc_n + 1;
        e.outs = {m_mode, m_up, clr_o, load_o, step_o, done_o, m_lv};
        exp_q.push_back(e);
    endtask

    // Monitor: compare queued expectations against the DUT away from the active edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc_n) begin
            check("stale_expectation", 32'(exp_q[0].cyc), 32'(cyc_n));
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc_n) begin
            check("outputs", 32'({state, cnt_up, cnt_clr, cnt_load, cnt_step, done, load_val}),
                  32'(exp_q[0].outs));
            void'(exp_q.pop_front());
        end
    end

    // Called at posedge+1: model the next edge, then advance to just past it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_start();
        start_btn = 1'b1; step(1); start_btn = 1'b0; step(1);
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        check("rst_strobes", 32'({cnt_clr, cnt_load, cnt_step, done}), 32'h0);
        check("rst_state", 32'(state), 32'(ST_IDLE));
        check("rst_up_lv", 32'({cnt_up, load_val}), 32'h100);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold", 32'({state, cnt_clr, cnt_load, cnt_step, done}), 32'h0);
        clr_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        // Reset then run
        do_reset();
        step(2);
        press_start();
        step(12);
        // Pause and resume, keeping prescaler phase
        step(1);
        press_start();
        step(5);
        press_start();
        step(6);
        // Load wins over a coincident start
        data = 8'hA5;
        load_btn = 1'b1; start_btn = 1'b1; step(1);
        load_btn = 1'b0; start_btn = 1'b0; data = 8'h3C; step(3);
        press_start();
        step(6);
        // One-shot terminal count up
        one_shot = 1'b1; q = 8'hFF;
        step(8);
        // Mode held for 50 cycles toggles once; then one-shot terminal count down
        mode_btn = 1'b1; step(50); mode_btn = 1'b0; step(1);
        q = 8'h00;
        press_start();
        step(8);
        // Plain wrap with one_shot=0 at q=FF, direction back to up
        one_shot = 1'b0; q = 8'hFF;
        mode_btn = 1'b1; step(1); mode_btn = 1'b0; step(1);
        press_start();
        step(10);
        // run_sw low freezes the prescaler
        run_sw = 1'b0; step(7); run_sw = 1'b1; step(5);
        // Clear during RUN, then clear during LOAD
        clear_btn = 1'b1; step(1); clear_btn = 1'b0; step(2);
        load_btn = 1'b1; step(1); load_btn = 1'b0; clear_btn = 1'b1; step(1);
        clear_btn = 1'b0; step(3);
        // Start held through reset release yields no edge until re-pressed
        press_start();
        step(3);
        start_btn = 1'b1;
        do_reset();
        step(6);
        start_btn = 1'b0; step(1);
        start_btn = 1'b1; step(1);
        start_btn = 1'b0; step(6);

        // Randomized phase, with one reset landing mid-operation
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(11) == 0) start_btn = ~start_btn;
            if ($urandom_range(39) == 0) load_btn  = ~load_btn;
            if ($urandom_range(19) == 0) mode_btn  = ~mode_btn;
            if ($urandom_range(59) == 0) clear_btn = ~clear_btn;
            if ($urandom_range(29) == 0) run_sw    = ~run_sw;
            if ($urandom_range(9)  == 0) one_shot  = ~one_shot;
            case ($urandom_range(3))
                0:       q = 8'h00;
                1:       q = 8'hFF;
                default: q = 8'($urandom);
            endcase
            data = 8'($urandom);
            if (i == 1500) do_reset();
            step(1);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Sequencing controller for the 8-bit up/down counter datapath. It sits between the debounced front-panel buttons/switches and the counter.
- Converts button levels into single-cycle command strobes and generates the count-step tick from the 100 MHz system clock.
- Runs a RUN/PAUSE/LOAD state machine and detects terminal count for one-shot operation. The counter's q output feeds back into this block.

Parameters:
- WIDTH, 8: counter data width.
- TICK_DIV, 100000000: clk cycles per count step (1 Hz at 100 MHz); minimum 2.
- TICK_W, 27: prescaler width; must satisfy 2^TICK_W >= TICK_DIV.

Ports:
- clk, in, 1: 100 MHz system clock.
- clr_n, in, 1: asynchronous active-low reset.
- start_btn, in, 1: debounced level; a rising edge toggles run/pause.
- load_btn, in, 1: debounced level; a rising edge requests a load of data.
- mode_btn, in, 1: debounced level; a rising edge toggles count direction.
- clear_btn, in, 1: debounced level; a rising edge clears the counter and returns to IDLE.
- run_sw, in, 1: level enable; 0 freezes the prescaler while in RUN.
- one_shot, in, 1: level; 1 stops at terminal count instead of wrapping.
- data, in, WIDTH: switch load value.
- q, in, WIDTH: counter value feedback.
- cnt_clr, out, 1: one-cycle clear strobe to the counter.
- cnt_load, out, 1: one-cycle load strobe to the counter.
- load_val, out, WIDTH: value to load; valid while cnt_load=1, held otherwise.
- cnt_step, out, 1: one-cycle count-enable strobe.
- cnt_up, out, 1: direction; 1 = up, 0 = down.
- state, out, 2: IDLE=00, RUN=01, PAUSE=10, LOAD=11.
- done, out, 1: one-cycle pulse when one-shot terminal count is reached.

Behaviour:
- Reset values (asynchronous on clr_n=0):
  - state=IDLE; cnt_clr=0, cnt_load=0, cnt_step=0, done=0.
  - cnt_up=1, load_val=0, prescaler=0.
  - All button history registers=1, so a button held through reset produces no edge.
- Edge detection:
  - rise_x = btn_x & ~btn_x_q, using one history register per button.
  - Each physical press yields exactly one rise.
- All outputs are registered. A strobe appears the cycle after its rising-edge input is sampled (latency 1).
- Command priority within a single cycle: clear_rise > load_rise > start_rise.
  - mode_rise is independent of this priority and always takes effect.
- clear_rise, from any state: cnt_clr=1 for one cycle, state->IDLE, prescaler->0.
- mode_rise, in any state: cnt_up toggles. The new direction applies from the next cnt_step.
- IDLE:
  - start_rise -> RUN, prescaler=0.
  - load_rise -> LOAD.
- RUN:
  - The prescaler increments each cycle while run_sw=1 and holds while run_sw=0.
  - At prescaler==TICK_DIV-1 it wraps to 0 and a tick occurs.
  - On a tick with one_shot=0: cnt_step=1 for one cycle. The counter wraps naturally (up 0xFF->0x00, down 0x00->0xFF).
  - On a tick with one_shot=1 and q terminal (q==all-ones when cnt_up=1, q==0 when cnt_up=0): no cnt_step; done=1 for one cycle; state->IDLE.
  - start_rise -> PAUSE, prescaler value retained.
  - load_rise -> LOAD.
  - Command strobes take priority over a coincident tick; the tick is dropped.
- PAUSE:
  - Prescaler frozen, no cnt_step.
  - start_rise -> RUN, resuming from the retained prescaler phase.
  - load_rise -> LOAD.
- LOAD (one cycle):
  - Entry captures data into load_val; cnt_load=1 during this cycle.
  - The next state is unconditionally PAUSE, with prescaler=0.
  - clear_rise during LOAD still wins: cnt_clr=1, state->IDLE, and the load strobe already issued stands.
- Mutual exclusion: at most one of cnt_clr, cnt_load, cnt_step is high in any cycle.
- done and cnt_step never coincide.
- The prescaler never exceeds TICK_DIV-1.
- Reset asserted mid-operation:
  - Strobes drop immediately and state returns to IDLE.
  - No strobe is issued on the first cycle after release, even if buttons are held.

Test Plan:
- Reset then run: TICK_DIV=4, clr_n low then high, pulse start_btn. Expect state=01 one cycle after the rise, then cnt_step high for 1 cycle every 4 cycles; no strobes during reset.
- Pause/resume: in RUN with prescaler=2, press start. Expect state=10 and no cnt_step. Press start again: expect state=01 and the first cnt_step exactly 1 cycle after resume (phase kept).
- Load: data=8'hA5, press load from RUN. Expect cnt_load=1 with load_val=8'hA5 for exactly 1 cycle, then state=10. Press load_btn and start_btn in the same cycle: LOAD wins.
- One-shot terminal: one_shot=1, cnt_up=1, q=8'hFF at a tick. Expect no cnt_step, done=1 for 1 cycle, state=00. Repeat with cnt_up=0 and q=8'h00; with one_shot=0 and q=8'hFF, expect cnt_step=1.
- Mode and clear: press mode twice. Expect cnt_up 1->0->1, one toggle per press even when held 50 cycles. Press clear during RUN: expect cnt_clr=1 for 1 cycle and state=00.
- Held-through-reset: start_btn=1 across clr_n release. Expect state remains 00 until start_btn falls and rises again.
